// File: rtl/regfile_write_scheduler_pkg.sv
// Shared sizes, grant encoding and helpers for the register file write scheduler.
package regfile_sched_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MDU
  } grant_t;

  // r0 is hardwired to zero, so any write aimed at it must be suppressed.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Pipeline-side bundle of the write scheduler: WB and MDU requests, decode operands, RF write port.
interface regfile_write_scheduler_if;
  import regfile_sched_pkg::*;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_stall;

  logic              mdu_issue;
  logic [ADDR_W-1:0] mdu_issue_rd;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;

  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] id_rd;
  logic              hazard_stall;

  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_write_data;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data,
    output id_valid, id_rs, id_rt, id_rd,
    input  wb_stall, mdu_ready, hazard_stall,
    input  rf_reg_write, rf_rd, rf_write_data, busy_vec
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  mdu_issue, mdu_issue_rd, mdu_valid, mdu_rd, mdu_data,
    input  id_valid, id_rs, id_rt, id_rd,
    output wb_stall, mdu_ready, hazard_stall,
    output rf_reg_write, rf_rd, rf_write_data, busy_vec
  );

endinterface

// File: rtl/regfile_write_scheduler_scoreboard.sv
// Busy scoreboard of registers awaiting an MDU result, with the decode hazard compare.
module rf_scoreboard
  import regfile_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs,
  input  logic [ADDR_W-1:0]   id_rt,
  input  logic [ADDR_W-1:0]   id_rd,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [IDX_W-1:0]    set_idx;
  logic [IDX_W-1:0]    clr_idx;
  logic                unused_addr_hi;

  assign set_idx = set_addr[IDX_W-1:0];
  assign clr_idx = clr_addr[IDX_W-1:0];

  // Only the low index bits address the scoreboard.
  assign unused_addr_hi = ^{set_addr[ADDR_W-1:IDX_W], clr_addr[ADDR_W-1:IDX_W],
                            id_rs[ADDR_W-1:IDX_W], id_rt[ADDR_W-1:IDX_W],
                            id_rd[ADDR_W-1:IDX_W]};

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_idx != '0))
      set_mask[set_idx] = 1'b1;
    if (clr_en)
      clr_mask[clr_idx] = 1'b1;
  end

  // Set is applied after clear so a reissue to the same register keeps it busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy <= '0;
    else
      busy <= (busy & ~clr_mask) | set_mask;
  end

  assign hazard = id_valid & (busy[id_rs[IDX_W-1:0]] |
                              busy[id_rt[IDX_W-1:0]] |
                              busy[id_rd[IDX_W-1:0]]);

  assign busy_vec = busy;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates WB and MDU onto the single register file write port and tracks MDU hazards.
module regfile_write_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_scheduler_if.slave bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt;
  logic              starved;
  logic              mdu_ready_c;
  grant_t            grant;
  logic [ADDR_W-1:0] gnt_rd;
  logic [DATA_W-1:0] gnt_data;

  logic              rf_reg_write_q;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0] rf_write_data_q;

  // mdu_ready is derived from WB and the counter only, never from mdu_valid.
  always_comb begin
    starved     = (starve_cnt == CNT_MAX);
    mdu_ready_c = !bus.wb_valid || starved;
    grant       = GNT_NONE;
    gnt_rd      = '0;
    gnt_data    = '0;
    if (bus.mdu_valid && mdu_ready_c) begin
      grant    = GNT_MDU;
      gnt_rd   = bus.mdu_rd;
      gnt_data = bus.mdu_data;
    end else if (bus.wb_valid) begin
      grant    = GNT_WB;
      gnt_rd   = bus.wb_rd;
      gnt_data = bus.wb_data;
    end
  end

  assign bus.mdu_ready = mdu_ready_c;
  assign bus.wb_stall  = bus.wb_valid && bus.mdu_valid && starved;

  // Counts consecutive cycles the MDU lost to WB; any MDU win restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant == GNT_MDU)
      starve_cnt <= '0;
    else if (bus.wb_valid && bus.mdu_valid)
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  // Address and data are captured on every grant; the strobe is dropped for r0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_reg_write_q  <= 1'b0;
      rf_rd_q         <= '0;
      rf_write_data_q <= '0;
    end else if (grant != GNT_NONE) begin
      rf_reg_write_q  <= !is_zero_reg(gnt_rd);
      rf_rd_q         <= gnt_rd;
      rf_write_data_q <= gnt_data;
    end else begin
      rf_reg_write_q  <= 1'b0;
    end
  end

  assign bus.rf_reg_write  = rf_reg_write_q;
  assign bus.rf_rd         = rf_rd_q;
  assign bus.rf_write_data = rf_write_data_q;

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.mdu_issue),
    .set_addr (bus.mdu_issue_rd),
    .clr_en   (grant == GNT_MDU),
    .clr_addr (bus.mdu_rd),
    .id_valid (bus.id_valid),
    .id_rs    (bus.id_rs),
    .id_rt    (bus.id_rt),
    .id_rd    (bus.id_rd),
    .hazard   (bus.hazard_stall),
    .busy_vec (bus.busy_vec)
  );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed table-driven bench for regfile_write_scheduler plus hand-written scoreboard/reset sequences.
module tb_regfile_write_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regfile_write_scheduler_if bus();

  regfile_write_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        exp_wb_stall;
    logic        exp_mdu_ready;
    logic        exp_we;
    logic        chk_addr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  // Register file model: commits on the falling edge like the real array.
  logic [31:0] rf_model [16];
  always @(negedge clk) begin
    if (bus.rf_reg_write)
      rf_model[bus.rf_rd[3:0]] <= bus.rf_write_data;
  end

  // Illegal stimulus guards.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mdu_issue && bus.hazard_stall) begin
        failures++;
        $display("[TB] FAIL illegal_issue actual=mdu_issue during hazard_stall required=no issue");
      end
      if (bus.wb_valid && bus.mdu_valid && (bus.wb_rd == bus.mdu_rd) &&
          (bus.wb_rd != 5'd0) && bus.busy_vec[bus.wb_rd[3:0]]) begin
        failures++;
        $display("[TB] FAIL illegal_same_rd actual=rd %0d busy required=distinct", bus.wb_rd);
      end
    end
  end

  function automatic vec_t mk(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md,
                              input logic es, input logic er, input logic ew,
                              input logic ca, input logic [4:0] erd, input logic [31:0] ed);
    vec_t v;
    v.wb_valid = wv;  v.wb_rd = wr;  v.wb_data = wd;
    v.mdu_valid = mv; v.mdu_rd = mr; v.mdu_data = md;
    v.exp_wb_stall = es; v.exp_mdu_ready = er; v.exp_we = ew;
    v.chk_addr = ca; v.exp_rd = erd; v.exp_data = ed;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.mdu_issue = 0; bus.mdu_issue_rd = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.wb_valid  = v.wb_valid;  bus.wb_rd  = v.wb_rd;  bus.wb_data  = v.wb_data;
    bus.mdu_valid = v.mdu_valid; bus.mdu_rd = v.mdu_rd; bus.mdu_data = v.mdu_data;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    // Arbitration table, run from reset (starve counter = 0).
    vecs[0]  = mk(1, 5, 32'h964EB,    0, 0,  32'h0,    0, 0, 1, 1, 5,  32'h964EB);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0,  32'h0,    0, 1, 0, 1, 5,  32'h964EB);
    vecs[2]  = mk(0, 0, 32'h0,        1, 9,  32'hA5A5, 0, 1, 1, 1, 9,  32'hA5A5);
    vecs[3]  = mk(1, 2, 32'h11,       1, 11, 32'hBEEF, 0, 0, 1, 1, 2,  32'h11);
    vecs[4]  = mk(1, 3, 32'h22,       1, 11, 32'hBEEF, 0, 0, 1, 1, 3,  32'h22);
    vecs[5]  = mk(1, 4, 32'h33,       0, 0,  32'h0,    0, 0, 1, 1, 4,  32'h33);
    vecs[6]  = mk(1, 6, 32'h44,       1, 11, 32'hBEEF, 0, 0, 1, 1, 6,  32'h44);
    vecs[7]  = mk(1, 8, 32'h55,       1, 11, 32'hBEEF, 0, 0, 1, 1, 8,  32'h55);
    vecs[8]  = mk(1, 8, 32'h55,       1, 11, 32'hBEEF, 1, 1, 1, 1, 11, 32'hBEEF);
    vecs[9]  = mk(1, 8, 32'h55,       1, 12, 32'hC0DE, 0, 0, 1, 1, 8,  32'h55);
    vecs[10] = mk(0, 0, 32'h0,        1, 12, 32'hC0DE, 0, 1, 1, 1, 12, 32'hC0DE);
    vecs[11] = mk(1, 10, 32'h66,      1, 13, 32'h77,   0, 0, 1, 1, 10, 32'h66);
    vecs[12] = mk(1, 0, 32'hFFFFFFFF, 1, 13, 32'h77,   0, 0, 0, 0, 0,  32'h0);
    vecs[13] = mk(0, 0, 32'h0,        1, 13, 32'h77,   0, 1, 1, 1, 13, 32'h77);
    vecs[14] = mk(0, 0, 32'h0,        1, 0,  32'h1234, 0, 1, 0, 0, 0,  32'h0);
    vecs[15] = mk(1, 1, 32'h99,       0, 0,  32'h0,    0, 0, 1, 1, 1,  32'h99);

    reset = 1'b1;
    idle_inputs();
    #3;
    check_output("reset_we",   {31'b0, bus.rf_reg_write}, 32'h0);
    check_output("reset_rd",   {27'b0, bus.rf_rd},        32'h0);
    check_output("reset_data", bus.rf_write_data,         32'h0);
    check_output("reset_busy", {16'b0, bus.busy_vec},     32'h0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("row%0d_wb_stall", i),  {31'b0, bus.wb_stall},  {31'b0, vecs[i].exp_wb_stall});
      check_output($sformatf("row%0d_mdu_ready", i), {31'b0, bus.mdu_ready}, {31'b0, vecs[i].exp_mdu_ready});
      tick();
      check_output($sformatf("row%0d_we", i), {31'b0, bus.rf_reg_write}, {31'b0, vecs[i].exp_we});
      if (vecs[i].chk_addr) begin
        check_output($sformatf("row%0d_rd", i),   {27'b0, bus.rf_rd}, {27'b0, vecs[i].exp_rd});
        check_output($sformatf("row%0d_data", i), bus.rf_write_data,  vecs[i].exp_data);
      end
    end
    idle_inputs();

    // RAW hazard on r7 held until the MDU result is granted.
    bus.mdu_issue = 1; bus.mdu_issue_rd = 7;
    tick();
    check_output("r7_busy_set", {16'b0, bus.busy_vec}, 32'h0080);
    bus.mdu_issue = 0; bus.mdu_issue_rd = 0;
    bus.id_valid = 1; bus.id_rs = 7; bus.id_rt = 1; bus.id_rd = 2;
    #1;
    check_output("r7_hazard_wait", {31'b0, bus.hazard_stall}, 32'h1);
    tick();
    bus.mdu_valid = 1; bus.mdu_rd = 7; bus.mdu_data = 32'h113D4;
    #1;
    check_output("r7_hazard_grant_cycle", {31'b0, bus.hazard_stall}, 32'h1);
    check_output("r7_mdu_ready",          {31'b0, bus.mdu_ready},    32'h1);
    tick();
    check_output("r7_busy_clear", {16'b0, bus.busy_vec}, 32'h0);
    check_output("r7_rf_we",      {31'b0, bus.rf_reg_write}, 32'h1);
    check_output("r7_rf_rd",      {27'b0, bus.rf_rd}, 32'h7);
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    #1;
    check_output("r7_hazard_released", {31'b0, bus.hazard_stall}, 32'h0);
    @(negedge clk);
    #1;
    check_output("r7_decode_read", rf_model[7], 32'h113D4);
    tick();
    idle_inputs();

    // Same-cycle set and clear of r3: the set wins.
    bus.mdu_issue = 1; bus.mdu_issue_rd = 3;
    tick();
    check_output("r3_busy_set", {16'b0, bus.busy_vec}, 32'h0008);
    bus.mdu_valid = 1; bus.mdu_rd = 3; bus.mdu_data = 32'h3;
    #1;
    check_output("r3_mdu_ready", {31'b0, bus.mdu_ready}, 32'h1);
    tick();
    check_output("r3_set_wins", {16'b0, bus.busy_vec}, 32'h0008);
    bus.mdu_issue = 0; bus.mdu_issue_rd = 0;
    tick();
    check_output("r3_busy_clear", {16'b0, bus.busy_vec}, 32'h0);
    idle_inputs();

    // Issue to r0 never marks it busy.
    bus.mdu_issue = 1; bus.mdu_issue_rd = 0;
    tick();
    check_output("r0_issue_busy", {16'b0, bus.busy_vec}, 32'h0);
    idle_inputs();

    // Reset mid-operation with busy bits set and the starve counter at 3.
    bus.mdu_issue = 1; bus.mdu_issue_rd = 4;
    tick();
    bus.mdu_issue_rd = 7;
    tick();
    check_output("mid_busy_before", {16'b0, bus.busy_vec}, 32'h0090);
    bus.mdu_issue = 0; bus.mdu_issue_rd = 0;
    bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'hAB;
    bus.mdu_valid = 1; bus.mdu_rd = 4; bus.mdu_data = 32'hCD;
    tick();
    tick();
    tick();
    check_output("mid_mdu_ready_before", {31'b0, bus.mdu_ready},    32'h0);
    check_output("mid_we_before",        {31'b0, bus.rf_reg_write}, 32'h1);
    reset = 1'b1;
    idle_inputs();
    #1;
    check_output("mid_reset_busy", {16'b0, bus.busy_vec},     32'h0);
    check_output("mid_reset_we",   {31'b0, bus.rf_reg_write}, 32'h0);
    check_output("mid_reset_rd",   {27'b0, bus.rf_rd},        32'h0);
    check_output("mid_reset_data", bus.rf_write_data,         32'h0);
    tick();
    reset = 1'b0;

    // Starvation from a cleared counter: four WB wins, then forced MDU.
    bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'hAB;
    bus.mdu_valid = 1; bus.mdu_rd = 4; bus.mdu_data = 32'hCD;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output($sformatf("starve%0d_mdu_ready", i), {31'b0, bus.mdu_ready}, (i == 4) ? 32'h1 : 32'h0);
      check_output($sformatf("starve%0d_wb_stall", i),  {31'b0, bus.wb_stall},  (i == 4) ? 32'h1 : 32'h0);
      tick();
    end
    check_output("starve_rf_rd",   {27'b0, bus.rf_rd}, 32'h4);
    check_output("starve_rf_data", bus.rf_write_data,  32'hCD);
    bus.mdu_rd = 5; bus.mdu_data = 32'hEF;
    #1;
    check_output("starve_restart_ready", {31'b0, bus.mdu_ready}, 32'h0);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
